// File: rtl/fpu_addsub_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub_if
// Description : Operand/result bundle for the fpu_addsub block. The master
//               side (execute stage) drives a request and operands; the slave
//               side (the adder) answers with busy/done, result and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_addsub_if #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         start_i;
    logic         op_sub_i;
    logic [W-1:0] op_a_i;
    logic [W-1:0] op_b_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] data_o;
    logic [3:0]   status_o;

    modport master (
        output start_i, op_sub_i, op_a_i, op_b_i,
        input  busy_o, done_o, data_o, status_o
    );

    modport slave (
        input  start_i, op_sub_i, op_a_i, op_b_i,
        output busy_o, done_o, data_o, status_o
    );
endinterface
`default_nettype wire

// File: rtl/fpu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : fpu_addsub
// Description : Multi-cycle floating-point adder/subtractor with generic
//               exponent/fraction widths. Flush-to-zero inputs, start/busy/
//               done handshake, status = {EXACT, OVERFLOW, UNDERFLOW, INEXACT}.
//               Optional macro FPU_ROUND_RNE_EN selects round-to-nearest-even;
//               without it the result is truncated (round toward zero).
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub #(
    parameter int EXP_W = 6,
    parameter int MAN_W = 25
) (
    input  logic         clk,
    input  logic         rst,
    fpu_addsub_if.slave  bus
);
    localparam int W     = 1 + EXP_W + MAN_W;
    // Aligned-significand path: carry, hidden, fraction, guard, round.
    localparam int SH_W  = MAN_W + 4;
    // Same path with the sticky bit appended as the LSB.
    localparam int EXT_W = MAN_W + 5;
    localparam int LZ_W  = $clog2(EXT_W);
    // Signed exponent wide enough for carry growth and a full left shift.
    localparam int XW    = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE = XW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          a_q, b_q;          // b_q carries the effective sign
    logic [EXT_W-1:0]      big_q, small_q, acc_q;
    logic signed [XW-1:0]  exp_q;
    logic                  sign_q, sub_q;
    logic [W-1:0]          data_q;
    logic [3:0]            status_q;

    // ------------------------------------------------------------------
    // Alignment: order operands by magnitude, shift the smaller one.
    // ------------------------------------------------------------------
    logic [EXP_W-1:0] w_ea, w_eb, w_big_e, w_small_e, w_diff;
    logic [W-2:0]     w_mag_a, w_mag_b;
    logic [MAN_W:0]   w_sig_a, w_sig_b, w_big_sig, w_small_sig;
    logic [SH_W-1:0]  w_small_full, w_shifted, w_lost;
    logic             w_swap, w_sticky;

    assign w_ea        = a_q[W-2:MAN_W];
    assign w_eb        = b_q[W-2:MAN_W];
    // exp = 0 reads as zero regardless of the fraction field
    assign w_mag_a     = (w_ea == '0) ? '0 : a_q[W-2:0];
    assign w_mag_b     = (w_eb == '0) ? '0 : b_q[W-2:0];
    assign w_sig_a     = (w_ea == '0) ? '0 : {1'b1, a_q[MAN_W-1:0]};
    assign w_sig_b     = (w_eb == '0) ? '0 : {1'b1, b_q[MAN_W-1:0]};
    assign w_swap      = (w_mag_b > w_mag_a);
    assign w_big_e     = w_swap ? w_eb : w_ea;
    assign w_small_e   = w_swap ? w_ea : w_eb;
    assign w_big_sig   = w_swap ? w_sig_b : w_sig_a;
    assign w_small_sig = w_swap ? w_sig_a : w_sig_b;
    assign w_diff      = w_big_e - w_small_e;
    assign w_small_full = {1'b0, w_small_sig, 2'b00};
    // Shifts of SH_W or more give zero data and an all-ones mask, so large
    // differences collapse into the sticky bit without a special case.
    assign w_shifted   = w_small_full >> w_diff;
    assign w_lost      = w_small_full & ~({SH_W{1'b1}} << w_diff);
    assign w_sticky    = |w_lost;

    // ------------------------------------------------------------------
    // Normalisation: leading-zero count below the carry position.
    // ------------------------------------------------------------------
    logic [LZ_W-1:0] w_lz;
    logic            w_found;

    // Priority search for the first set bit from the hidden position down.
    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int i = EXT_W - 2; i >= 0; i--) begin
            if (!w_found && acc_q[i]) begin
                w_found = 1'b1;
                w_lz    = LZ_W'(EXT_W - 2 - i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Rounding and exception selection.
    // ------------------------------------------------------------------
    logic [MAN_W-1:0]     w_frac, w_frac_r;
    logic                 w_g, w_r, w_s, w_up, w_rc, w_inexact;
    logic                 w_a_inf, w_b_inf;
    logic signed [XW-1:0] w_exp_r;
    logic [W-1:0]         w_res;
    logic [3:0]           w_stat;

    assign w_frac    = acc_q[EXT_W-3:3];
    assign w_g       = acc_q[2];
    assign w_r       = acc_q[1];
    assign w_s       = acc_q[0];
    assign w_inexact = w_g | w_r | w_s;
`ifdef FPU_ROUND_RNE_EN
    // Round up above half, or on an exact half when the LSB is odd.
    assign w_up      = w_g & (w_r | w_s | w_frac[0]);
`else
    assign w_up      = 1'b0;
`endif
    assign {w_rc, w_frac_r} = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_up};
    assign w_exp_r   = exp_q + $signed({{(XW-1){1'b0}}, w_rc});
    assign w_a_inf   = (w_ea == {EXP_W{1'b1}});
    assign w_b_inf   = (w_eb == {EXP_W{1'b1}});

    // Result/status selection, infinity inputs taking precedence.
    always_comb begin
        w_res  = '0;
        w_stat = 4'b0000;
        if (w_a_inf || w_b_inf) begin
            w_res  = {a_q[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_stat = 4'b0100;
        end else if (!acc_q[EXT_W-2]) begin
            // hidden bit clear after normalisation means an exact zero: +0
            w_res  = '0;
            w_stat = 4'b1000;
        end else if (exp_q[XW-1] || (exp_q == '0)) begin
            w_res  = {sign_q, {(W-1){1'b0}}};
            w_stat = 4'b0011;
        end else if (w_exp_r >= EXP_MAX) begin
            w_res  = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_stat = 4'b0101;
        end else begin
            w_res  = {sign_q, w_exp_r[EXP_W-1:0], w_frac_r};
            w_stat = w_inexact ? 4'b0001 : 4'b1000;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed walk through the pipeline stages; start only matters in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start_i) state_d = S_ALIGN;
            S_ALIGN: state_d = S_ADD;
            S_ADD:   state_d = S_NORM;
            S_NORM:  state_d = S_ROUND;
            S_ROUND: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers, each stage updating only in its own state.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            big_q    <= '0;
            small_q  <= '0;
            acc_q    <= '0;
            exp_q    <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            data_q   <= '0;
            status_q <= 4'b0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        a_q <= bus.op_a_i;
                        b_q <= {bus.op_b_i[W-1] ^ bus.op_sub_i, bus.op_b_i[W-2:0]};
                    end
                end
                S_ALIGN: begin
                    big_q   <= {1'b0, w_big_sig, 3'b000};
                    small_q <= {w_shifted, w_sticky};
                    exp_q   <= $signed({{(XW-EXP_W){1'b0}}, w_big_e});
                    sign_q  <= w_swap ? b_q[W-1] : a_q[W-1];
                    sub_q   <= a_q[W-1] ^ b_q[W-1];
                end
                S_ADD: begin
                    acc_q <= sub_q ? (big_q - small_q) : (big_q + small_q);
                end
                S_NORM: begin
                    if (acc_q[EXT_W-1]) begin
                        acc_q <= {1'b0, acc_q[EXT_W-1:2], acc_q[1] | acc_q[0]};
                        exp_q <= exp_q + EXP_ONE;
                    end else begin
                        acc_q <= acc_q << w_lz;
                        exp_q <= exp_q - $signed({{(XW-LZ_W){1'b0}}, w_lz});
                    end
                end
                S_ROUND: begin
                    data_q   <= w_res;
                    status_q <= w_stat;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy_o   = (state_q != S_IDLE);
    assign bus.done_o   = (state_q == S_DONE);
    assign bus.data_o   = data_q;
    assign bus.status_o = status_q;
endmodule
`default_nettype wire

// File: tb/tb_fpu_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_addsub
// Description : Self-checking bench for fpu_addsub (6-bit exponent, 25-bit
//               fraction). Reference arithmetic uses exact wide integers.
//               Honours FPU_ROUND_RNE_EN the same way as the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_addsub;
    localparam int EXP_W = 6;
    localparam int MAN_W = 25;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_addsub_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();
    fpu_addsub #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [3:0]  status;
        int          c;
    } exp_t;

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          n_done  = 0;
    logic [31:0] hold_d  = '0;
    logic [3:0]  hold_s  = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Exact value: each operand becomes sig * 2^(exp-1) in units of
    // 2^(1-bias-MAN_W); the sum is then rounded from its true MSB.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic        sa, sb, s, inexact;
        logic [5:0]  ea, eb;
        logic [127:0] ma, mb, m, keep, rem, half;
        int          p, er, sh;
        sa = a[31]; sb = b[31] ^ sub; ea = a[30:25]; eb = b[30:25];
        if (ea == 6'h3F || eb == 6'h3F) return {4'b0100, sa, 6'h3F, 25'd0};
        ma = (ea == 0) ? 128'd0 : (128'({1'b1, a[24:0]}) << (int'(ea) - 1));
        mb = (eb == 0) ? 128'd0 : (128'({1'b1, b[24:0]}) << (int'(eb) - 1));
        if (ma >= mb) begin
            m = (sa == sb) ? ma + mb : ma - mb; s = sa;
        end else begin
            m = (sa == sb) ? ma + mb : mb - ma; s = sb;
        end
        if (m == 0) return {4'b1000, 32'd0};
        p = 0;
        for (int i = 0; i < 128; i++) if (m[i]) p = i;
        er = 1 + p - MAN_W;
        if (er <= 0) return {4'b0011, s, 31'd0};
        sh      = p - MAN_W;
        keep    = m >> sh;
        rem     = m - (keep << sh);
        inexact = (rem != 0);
`ifdef FPU_ROUND_RNE_EN
        if (sh > 0) begin
            half = 128'd1 << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        end
`else
        half = 128'd0;
`endif
        if (keep == (128'd1 << (MAN_W + 1))) begin
            keep = keep >> 1;
            er   = er + 1;
        end
        if (er >= 63) return {4'b0101, s, 6'h3F, 25'd0};
        return {(inexact ? 4'b0001 : 4'b1000), s, 6'(er), keep[24:0]};
    endfunction

    // One clock: advance, then compare every output on the falling edge.
    task automatic step();
        bit e_done, e_busy;
        int age;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        e_done = 1'b0;
        e_busy = 1'b0;
        if (q.size() > 0) begin
            age    = cyc - q[0].c;
            e_busy = (age >= 1 && age <= 5);
            e_done = (age == 5);
        end
        if (e_done) begin
            hold_d = q[0].data;
            hold_s = q[0].status;
            void'(q.pop_front());
        end
        check("done", 64'(bus.done_o), 64'(e_done));
        check("busy", 64'(bus.busy_o), 64'(e_busy));
        check("data", 64'(bus.data_o), 64'(hold_d));
        check("status", 64'(bus.status_o), 64'(hold_s));
        if (bus.done_o) n_done++;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [35:0] m;
        m = model(a, b, sub);
        bus.op_a_i   = a;
        bus.op_b_i   = b;
        bus.op_sub_i = sub;
        bus.start_i  = 1'b1;
        q.push_back('{data: m[31:0], status: m[35:32], c: cyc});
        step();
        bus.start_i = 1'b0;
        for (int i = 0; i < 12 && q.size() > 0; i++) step();
        if (q.size() > 0) begin
            check("done_timeout", 64'(q.size()), 64'd0);
            q.delete();
        end
        step();  // leave the DONE cycle so the next start lands in IDLE
    endtask

    task automatic pin(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input logic [31:0] ed, input logic [3:0] es);
        logic [35:0] m;
        m = model(a, b, sub);
        check({name, "_model"}, 64'(m), 64'({es, ed}));
        issue(a, b, sub);
    endtask

    function automatic logic [31:0] mk(input logic s, input int e, input logic [24:0] f);
        return {s, 6'(e), f};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b;
        logic        sub;
        int          ea, eb, d, d0, c0;

        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.op_sub_i = 1'b0;
        bus.op_a_i   = '0;
        bus.op_b_i   = '0;
        repeat (3) step();
        rst = 1'b0;
        step();

        // Hand-computed anchors.
        pin("one_plus_one",  32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b1000);
        pin("one_minus_one", 32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b1000);
        pin("one_plus_neg1", 32'h3E000000, 32'hBE000000, 1'b0, 32'h00000000, 4'b1000);
        pin("1p5_plus_2p25", 32'h3F000000, 32'h40400000, 1'b0, 32'h41C00000, 4'b1000);
        pin("1p5_plus_0p5",  32'h3F000000, 32'h3C000000, 1'b0, 32'h40000000, 4'b1000);
        pin("tie_even",      32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0001);
`ifdef FPU_ROUND_RNE_EN
        pin("tie_odd",       32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0001);
`else
        pin("tie_odd",       32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000001, 4'b0001);
`endif
        pin("overflow",      32'h7C000000, 32'h7C000000, 1'b0, 32'h7E000000, 4'b0101);
        pin("inf_in",        32'h7E000000, 32'h3E000000, 1'b0, 32'h7E000000, 4'b0100);
        pin("inf_b_sub",     32'h3E000000, 32'hFE000000, 1'b1, 32'h7E000000, 4'b0100);
        pin("underflow",     32'h82000001, 32'h82000000, 1'b1, 32'h80000000, 4'b0011);
        pin("zero_operand",  32'h00000123, 32'h3E000000, 1'b0, 32'h3E000000, 4'b1000);

        // Start held high across the whole operation: exactly one done.
        d0 = n_done;
        bus.op_a_i   = 32'h3E000000;
        bus.op_b_i   = 32'h3E000000;
        bus.op_sub_i = 1'b0;
        bus.start_i  = 1'b1;
        q.push_back('{data: 32'h40000000, status: 4'b1000, c: cyc});
        for (int i = 0; i < 12 && q.size() > 0; i++) step();
        step();
        bus.start_i = 1'b0;
        repeat (10) step();
        check("held_start_single_done", 64'(n_done - d0), 64'd1);

        // Reset during the ADD cycle discards the operation.
        d0 = n_done;
        c0 = cyc;
        bus.op_a_i  = 32'h3F000000;
        bus.op_b_i  = 32'h3C000000;
        bus.start_i = 1'b1;
        q.push_back('{data: 32'h40000000, status: 4'b1000, c: c0});
        step();
        bus.start_i = 1'b0;
        step();
        rst = 1'b1;
        q.delete();
        hold_d = '0;
        hold_s = '0;
        step();
        check("abort_data", 64'(bus.data_o), 64'd0);
        check("abort_status", 64'(bus.status_o), 64'd0);
        rst = 1'b0;
        repeat (8) step();
        check("abort_no_done", 64'(n_done - d0), 64'd0);
        pin("after_abort", 32'h3F000000, 32'h3C000000, 1'b0, 32'h40000000, 4'b1000);

        // Randomised operations against the reference model.
        for (int n = 0; n < 250; n++) begin
            sub = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0: begin
                    a = $urandom;
                    b = $urandom;
                end
                1: begin
                    ea = $urandom_range(1, 62);
                    d  = $urandom_range(0, 30);
                    if ($urandom_range(0, 1) == 1) eb = (ea + d > 62) ? 62 : ea + d;
                    else                           eb = (ea > d) ? ea - d : 1;
                    a = mk(1'($urandom), ea, 25'($urandom));
                    b = mk(1'($urandom), eb, 25'($urandom));
                end
                2: begin
                    a = mk(1'($urandom), $urandom_range(1, 62), 25'($urandom));
                    b = a;
                    b[7:0] = 8'($urandom);
                    b[31]  = ~a[31] ^ sub;
                end
                default: begin
                    a = mk(1'($urandom), $urandom_range(1, 3), 25'($urandom));
                    b = mk(1'($urandom), $urandom_range(1, 3), 25'($urandom));
                end
            endcase
            issue(a, b, sub);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
